mem_dma_arbiter: RTL

- Sits between the 6502 core and the shared synchronous BRAM.
- Provides a page-copy DMA engine that the CPU triggers by writing a page number to TRIG_ADDR. The engine copies LEN bytes from {page,8'h00} to DST_BASE.
- Arbitrates the single memory port: the CPU owns it by default, and DMA owns it while active. The CPU is stalled via READY for the duration of the copy.

---
 rtl/mem_dma_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_dma_arbiter.sv
// rtl/mem_dma_arbiter.sv - 6502/BRAM port arbiter with a page-copy DMA engine stalling the core via READY
module mem_dma_arbiter #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] DST_BASE  = 16'h0300,
    parameter int          LEN       = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_dout,
    input  logic        i_cpu_rw,
    output logic        o_cpu_ready,
    input  logic [7:0]  i_mem_din,
    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_mem_dout,
    output logic        o_mem_rw,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_INDEX = 8'(LEN - 1);

    state_t     state;
    logic [7:0] index;
    logic [7:0] page;
    logic       grant;

    // Outputs are registered on entry to the state they belong to.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            index       <= 8'h00;
            page        <= 8'h00;
            grant       <= 1'b0;
            o_cpu_ready <= 1'b1;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!i_cpu_rw && i_cpu_addr == TRIG_ADDR) begin
                        page        <= i_cpu_dout;
                        state       <= S_HALT;
                        o_cpu_ready <= 1'b0;
                        o_busy      <= 1'b1;
                    end
                end
                // Core ignores READY on writes; only a read cycle proves it is frozen.
                S_HALT: begin
                    if (i_cpu_rw) begin
                        state <= S_READ;
                        grant <= 1'b1;
                    end
                end
                S_READ: begin
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    if (index == LAST_INDEX) begin
                        state       <= S_DONE;
                        grant       <= 1'b0;
                        index       <= 8'h00;
                        o_cpu_ready <= 1'b1;
                        o_busy      <= 1'b0;
                        o_done      <= 1'b1;
                    end else begin
                        index <= index + 8'd1;
                        state <= S_READ;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state       <= S_IDLE;
                    grant       <= 1'b0;
                    index       <= 8'h00;
                    o_cpu_ready <= 1'b1;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Write data comes straight from the BRAM read issued in the preceding READ cycle.
    always_comb begin
        o_mem_addr = i_cpu_addr;
        o_mem_dout = i_cpu_dout;
        o_mem_rw   = i_cpu_rw;
        if (grant) begin
            o_mem_dout = i_mem_din;
            if (state == S_WRITE) begin
                o_mem_addr = DST_BASE + {8'h00, index};
                o_mem_rw   = 1'b0;
            end else begin
                o_mem_addr = {page, index};
                o_mem_rw   = 1'b1;
            end
        end
    end

endmodule
